// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv row read path: FSM encoding and line-buffer id rotation.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] BUF_NONE = 2'd0;

  // Buffer ids live in 1..3; 0 is reserved for "no buffer".
  function automatic logic [1:0] buf_rotate(input logic [1:0] id);
    return (id == 2'd3) ? 2'd1 : id + 2'd1;
  endfunction

endpackage

// File: rtl/conv_buf_rotator.sv
// Tracks which line buffer holds the top row of the 3-row window and emits per-row buffer ids,
// zeroing the rows that fall into the top/bottom padding.
module conv_buf_rotator
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       advance,
  input  logic       active,
  input  logic       pad_top,
  input  logic       pad_bot,
  output logic [1:0] idx1,
  output logic [1:0] idx2,
  output logic [1:0] idx3
);

  logic [1:0] base;
  logic [1:0] base_p1;
  logic [1:0] base_p2;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      base <= 2'd1;
    end else if (advance) begin
      base <= buf_rotate(base);
    end
  end

  always_comb begin
    base_p1 = buf_rotate(base);
    base_p2 = buf_rotate(base_p1);
    idx1    = (active && !pad_top) ? base    : BUF_NONE;
    idx2    = active               ? base_p1 : BUF_NONE;
    idx3    = (active && !pad_bot) ? base_p2 : BUF_NONE;
  end

endmodule

// File: rtl/conv_row_read_scheduler.sv
// Sequences 3-row window reads for the conv buffers: word/half addressing, buffer rotation per
// output row, top/bottom zero padding and 1-cycle-delayed buffer ids for returning read data.
module conv_row_read_scheduler
  import conv_pkg::*;
#(
  parameter int ADR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_row_words,
  input  logic [CNT_W-1:0] cfg_num_rows,
  input  logic             stall,
  input  logic             next_row_ready,
  output logic [ADR_W-1:0] row1_buf_adr,
  output logic [ADR_W-1:0] row2_buf_adr,
  output logic [ADR_W-1:0] row3_buf_adr,
  output logic             row1_buf_word_select,
  output logic             row2_buf_word_select,
  output logic             row3_buf_word_select,
  output logic [1:0]       row1_buf_idx,
  output logic [1:0]       row2_buf_idx,
  output logic [1:0]       row3_buf_idx,
  output logic [ADR_W-1:0] row1_slab_adr,
  output logic [ADR_W-1:0] row2_slab_adr,
  output logic [ADR_W-1:0] row3_slab_adr,
  output logic [1:0]       row1_slab_idx,
  output logic [1:0]       row2_slab_idx,
  output logic [1:0]       row3_slab_idx,
  output logic             valid_row1_adr,
  output logic             valid_row2_adr,
  output logic             valid_row3_adr,
  output logic [1:0]       last_row1_buf_idx,
  output logic [1:0]       last_row2_buf_idx,
  output logic [1:0]       last_row3_buf_idx,
  output logic [1:0]       last_row1_slab_idx,
  output logic [1:0]       last_row2_slab_idx,
  output logic [1:0]       last_row3_slab_idx,
  output logic             busy,
  output logic             row_done,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] words_m1;
  logic [CNT_W-1:0] rows_m1;
  logic [CNT_W-1:0] word_cnt;
  logic             half_sel;
  logic [CNT_W-1:0] out_row;
  logic             row_done_p1;
  logic             accept;
  logic             issue;
  logic             last_issue;
  logic             rotate;
  logic             reading;
  logic [1:0]       idx1;
  logic [1:0]       idx2;
  logic [1:0]       idx3;
  logic [1:0]       idx1_p1;
  logic [1:0]       idx2_p1;
  logic [1:0]       idx3_p1;
  logic [ADR_W-1:0] adr;

  always_comb begin
    accept     = (state == ST_IDLE) && start;
    reading    = (state == ST_READ);
    issue      = reading && !stall;
    last_issue = issue && half_sel && (word_cnt == words_m1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rotate    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (cfg_num_rows == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (last_issue) begin
          state_nxt = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        // The final row finishes the layer without waiting for the loader.
        if (out_row == rows_m1) begin
          state_nxt = ST_DONE;
        end else if (next_row_ready) begin
          state_nxt = ST_READ;
          rotate    = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_m1    <= '0;
      rows_m1     <= '0;
      word_cnt    <= '0;
      half_sel    <= 1'b0;
      out_row     <= '0;
      row_done_p1 <= 1'b0;
      idx1_p1     <= BUF_NONE;
      idx2_p1     <= BUF_NONE;
      idx3_p1     <= BUF_NONE;
    end else begin
      row_done_p1 <= last_issue;
      idx1_p1     <= idx1;
      idx2_p1     <= idx2;
      idx3_p1     <= idx3;
      if (accept) begin
        words_m1 <= (cfg_row_words == '0) ? '0 : cfg_row_words - CNT_W'(1);
        rows_m1  <= cfg_num_rows - CNT_W'(1);
        word_cnt <= '0;
        half_sel <= 1'b0;
        out_row  <= '0;
      end
      if (issue) begin
        half_sel <= !half_sel;
        if (half_sel) begin
          word_cnt <= last_issue ? '0 : word_cnt + CNT_W'(1);
        end
      end
      if (rotate) begin
        out_row <= out_row + CNT_W'(1);
      end
    end
  end

  // A new layer restarts the rotation so row 0 always sits in buffers 1..3 from the top.
  conv_buf_rotator u_rotator (
    .clk     (clk),
    .reset   (reset),
    .init    (accept),
    .advance (rotate),
    .active  (reading),
    .pad_top (out_row == '0),
    .pad_bot (out_row == rows_m1),
    .idx1    (idx1),
    .idx2    (idx2),
    .idx3    (idx3)
  );

  always_comb begin
    adr                  = reading ? ADR_W'(word_cnt) : '0;
    row1_buf_adr         = adr;
    row2_buf_adr         = adr;
    row3_buf_adr         = adr;
    row1_slab_adr        = adr;
    row2_slab_adr        = adr;
    row3_slab_adr        = adr;
    row1_buf_word_select = reading && half_sel;
    row2_buf_word_select = reading && half_sel;
    row3_buf_word_select = reading && half_sel;
    row1_buf_idx         = idx1;
    row2_buf_idx         = idx2;
    row3_buf_idx         = idx3;
    row1_slab_idx        = idx1;
    row2_slab_idx        = idx2;
    row3_slab_idx        = idx3;
    valid_row1_adr       = issue && (idx1 != BUF_NONE);
    valid_row2_adr       = issue && (idx2 != BUF_NONE);
    valid_row3_adr       = issue && (idx3 != BUF_NONE);
    last_row1_buf_idx    = idx1_p1;
    last_row2_buf_idx    = idx2_p1;
    last_row3_buf_idx    = idx3_p1;
    last_row1_slab_idx   = idx1_p1;
    last_row2_slab_idx   = idx2_p1;
    last_row3_slab_idx   = idx3_p1;
    busy                 = reading || (state == ST_ADVANCE);
    row_done             = row_done_p1;
    done                 = (state == ST_DONE);
  end

endmodule

// File: tb/tb_conv_row_read_scheduler.sv
// Randomized bench for conv_row_read_scheduler against a per-layer issue-list reference model.
module tb_conv_row_read_scheduler;
  localparam int ADR_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset, start, stall, next_row_ready;
  logic [CNT_W-1:0] cfg_row_words, cfg_num_rows;
  logic [ADR_W-1:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
  logic [ADR_W-1:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
  logic row1_buf_word_select, row2_buf_word_select, row3_buf_word_select;
  logic [1:0] row1_buf_idx, row2_buf_idx, row3_buf_idx;
  logic [1:0] row1_slab_idx, row2_slab_idx, row3_slab_idx;
  logic valid_row1_adr, valid_row2_adr, valid_row3_adr;
  logic [1:0] last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
  logic [1:0] last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
  logic busy, row_done, done;

  conv_row_read_scheduler #(.ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_row_words(cfg_row_words),
    .cfg_num_rows(cfg_num_rows), .stall(stall), .next_row_ready(next_row_ready),
    .row1_buf_adr(row1_buf_adr), .row2_buf_adr(row2_buf_adr), .row3_buf_adr(row3_buf_adr),
    .row1_buf_word_select(row1_buf_word_select), .row2_buf_word_select(row2_buf_word_select),
    .row3_buf_word_select(row3_buf_word_select),
    .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx), .row3_buf_idx(row3_buf_idx),
    .row1_slab_adr(row1_slab_adr), .row2_slab_adr(row2_slab_adr), .row3_slab_adr(row3_slab_adr),
    .row1_slab_idx(row1_slab_idx), .row2_slab_idx(row2_slab_idx), .row3_slab_idx(row3_slab_idx),
    .valid_row1_adr(valid_row1_adr), .valid_row2_adr(valid_row2_adr),
    .valid_row3_adr(valid_row3_adr),
    .last_row1_buf_idx(last_row1_buf_idx), .last_row2_buf_idx(last_row2_buf_idx),
    .last_row3_buf_idx(last_row3_buf_idx),
    .last_row1_slab_idx(last_row1_slab_idx), .last_row2_slab_idx(last_row2_slab_idx),
    .last_row3_slab_idx(last_row3_slab_idx),
    .busy(busy), .row_done(row_done), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic             ws;
    logic [5:0]       idx;
    logic [2:0]       vld;
    bit               first;
  } iss_t;

  iss_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Window row k at output row r reads input row r-1+k, held in buffer ((r+k) mod 3)+1.
  task automatic build_model(input int w, input int r);
    int wn;
    logic [1:0] b [3];
    iss_t e;
    exp_q.delete();
    wn = (w == 0) ? 1 : w;
    for (int row = 0; row < r; row++) begin
      for (int k = 0; k < 3; k++) b[k] = 2'(((row + k) % 3) + 1);
      if (row == 0) b[0] = 2'd0;
      if (row == r - 1) b[2] = 2'd0;
      for (int a = 0; a < wn; a++) begin
        for (int h = 0; h < 2; h++) begin
          e.adr   = ADR_W'(a);
          e.ws    = h[0];
          e.idx   = {b[0], b[1], b[2]};
          e.vld   = {b[0] != 0, b[1] != 0, b[2] != 0};
          e.first = (a == 0) && (h == 0);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic logic [2:0] obs_vld();
    return {valid_row1_adr, valid_row2_adr, valid_row3_adr};
  endfunction

  function automatic logic [5:0] obs_idx();
    return {row1_buf_idx, row2_buf_idx, row3_buf_idx};
  endfunction

  function automatic logic [63:0] obs_all();
    return {obs_vld(), obs_idx(), row1_buf_adr, row3_slab_adr,
            last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
            row2_buf_word_select, busy, row_done, done};
  endfunction

  task automatic run_layer(input int w, input int r, input bit use_stall, input bit hold_test,
                           input int reset_after, input bit poke_start);
    int wn, rd_cnt, last_rd_cyc, wait_cnt;
    bit finished, waiting, prev_ready;
    iss_t e;
    wn = (w == 0) ? 1 : w;
    build_model(w, r);
    rd_cnt = 0; last_rd_cyc = -10; finished = 0; waiting = 0; wait_cnt = 0; prev_ready = 0;
    @(posedge clk); #1;
    cfg_row_words = CNT_W'(w); cfg_num_rows = CNT_W'(r);
    start = 1'b1; stall = 1'b0; next_row_ready = 1'b0;
    @(negedge clk);
    check("start_cycle_idle", {busy, obs_vld()}, 4'b0);
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = poke_start && (cyc == 3);
      cfg_row_words = start ? CNT_W'(w + 3) : CNT_W'(w);
      cfg_num_rows  = start ? CNT_W'(r + 2) : CNT_W'(r);
      stall = use_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      prev_ready = next_row_ready;
      if (hold_test) begin
        if (waiting) wait_cnt++;
        next_row_ready = waiting && (wait_cnt > 5);
      end else begin
        next_row_ready = 1'($urandom_range(0, 1));
      end
      reset = (cyc == reset_after);
      @(negedge clk);
      if (reset_after > 0 && cyc == reset_after + 1) begin
        check("reset_mid_all_zero", obs_all(), 64'd0);
        check("reset_mid_slab", {row1_slab_idx, row3_slab_idx, last_row2_slab_idx}, 6'd0);
        finished = 1;
      end else begin
        if (stall) check("stall_valid_low", obs_vld(), 3'b0);
        if (hold_test && waiting && !prev_ready && rd_cnt < r && obs_vld() == 3'b0) begin
          check("advance_hold_busy", busy, 1'b1);
        end else if (hold_test && waiting && !prev_ready && rd_cnt < r) begin
          check("advance_hold_no_issue", obs_vld(), 3'b0);
        end
        if (obs_vld() != 3'b0) begin
          waiting = 0;
          if (exp_q.size() == 0) begin
            check("extra_issue", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("adr", {row1_buf_adr, row2_buf_adr, row3_buf_adr}, {3{e.adr}});
            check("slab_adr", {row1_slab_adr, row2_slab_adr, row3_slab_adr}, {3{e.adr}});
            check("word_sel", {row1_buf_word_select, row2_buf_word_select,
                               row3_buf_word_select}, {3{e.ws}});
            check("buf_idx", obs_idx(), e.idx);
            check("slab_idx", {row1_slab_idx, row2_slab_idx, row3_slab_idx}, e.idx);
            check("valid", obs_vld(), e.vld);
            check("busy_issue", busy, 1'b1);
            if (!e.first) begin
              check("last_buf_idx", {last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx},
                    e.idx);
              check("last_slab_idx", {last_row1_slab_idx, last_row2_slab_idx,
                                      last_row3_slab_idx}, e.idx);
            end
          end
        end
        if (row_done) begin
          rd_cnt++;
          last_rd_cyc = cyc;
          check("row_done_remaining", 64'(exp_q.size()), 64'((r - rd_cnt) * 2 * wn));
          waiting = 1; wait_cnt = 0;
        end
        if (done) begin
          check("done_after_row_done", 64'(cyc - last_rd_cyc), 64'd1);
          check("done_rows", 64'(rd_cnt), 64'(r));
          check("done_queue_empty", 64'(exp_q.size()), 64'd0);
          check("done_busy_low", busy, 1'b0);
          finished = 1;
        end
      end
    end
    if (!finished) check("layer_timeout", 1, 0);
    @(posedge clk); #1;
    start = 0; stall = 0; reset = 0; next_row_ready = 0;
    @(negedge clk);
    check("post_layer_idle", {busy, done, row_done, obs_vld()}, 6'b0);
  endtask

  task automatic run_zero_rows();
    int seen, at;
    seen = 0; at = -1;
    @(posedge clk); #1;
    cfg_num_rows = '0; cfg_row_words = CNT_W'(2); start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("zero_rows_no_valid", {busy, obs_vld()}, 4'b0);
      if (done) begin seen++; at = cyc; end
    end
    check("zero_rows_done_once", 64'(seen), 64'd1);
    check("zero_rows_done_cycle", 64'(at), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; next_row_ready = 1'b0;
    cfg_row_words = '0; cfg_num_rows = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs_all(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", obs_all(), 64'd0);

    run_layer(2, 3, 1'b0, 1'b1, -1, 1'b0);
    run_layer(3, 4, 1'b1, 1'b0, -1, 1'b1);
    run_layer(0, 2, 1'b1, 1'b0, -1, 1'b0);
    run_layer(2, 1, 1'b1, 1'b0, -1, 1'b0);
    run_zero_rows();
    run_layer(3, 3, 1'b0, 1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_layer($urandom_range(1, 4), $urandom_range(1, 5), 1'b1, 1'($urandom_range(0, 1)),
                -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
